// File: rtl/ubitz_dock_pkg.sv
// ubitz_dock_pkg: shared Dock config-bus state encoding and defaults
package ubitz_dock_pkg;
    localparam int CFG_ADDR_WIDTH_DEFAULT = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } spi_wr_state_e;
endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: brings the SPI pins into clk and flags sclk rise and cs_n edges
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_sclk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic mosi,
    output logic cs_n,
    output logic sclk_rise,
    output logic cs_fall,
    output logic cs_rise,
    output logic settled
);
    logic [STAGES-1:0] sclk_sr, cs_sr, mosi_sr, vld_sr;
    logic sclk_d, cs_d;
    // vld_sr tracks when the synchronized copies stop showing reset values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sr <= '0;
            cs_sr   <= '1;
            mosi_sr <= '0;
            vld_sr  <= '0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            sclk_sr <= {sclk_sr[STAGES-2:0], spi_sclk};
            cs_sr   <= {cs_sr[STAGES-2:0], spi_cs_n};
            mosi_sr <= {mosi_sr[STAGES-2:0], spi_mosi};
            vld_sr  <= {vld_sr[STAGES-2:0], 1'b1};
            sclk_d  <= sclk_sr[STAGES-1];
            cs_d    <= cs_sr[STAGES-1];
        end
    end
    assign mosi      = mosi_sr[STAGES-1];
    assign cs_n      = cs_sr[STAGES-1];
    assign settled   = vld_sr[STAGES-1];
    assign sclk_rise = sclk_sr[STAGES-1] && !sclk_d;
    assign cs_fall   = !cs_sr[STAGES-1] && cs_d;
    assign cs_rise   = cs_sr[STAGES-1] && !cs_d;
endmodule

// File: rtl/cfg_spi_writer.sv
// cfg_spi_writer: SPI slave turning {addr, data...} frames into Dock config-bus writes
module cfg_spi_writer
    import ubitz_dock_pkg::*;
#(
    parameter int CFG_ADDR_WIDTH = CFG_ADDR_WIDTH_DEFAULT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spi_sclk,
    input  logic                      spi_cs_n,
    input  logic                      spi_mosi,
    output logic                      cfg_we,
    output logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
    output logic [7:0]                cfg_wdata,
    output logic                      busy,
    output logic                      frame_err,
    output logic [7:0]                wr_count
);
    localparam int AW = CFG_ADDR_WIDTH;
    spi_wr_state_e state, state_nx;
    logic mosi_s, cs_n_s, sclk_rise, cs_fall, cs_rise, settled;
    logic armed, shift, byte_done, write;
    logic [2:0] bit_cnt;
    logic [6:0] sh;
    logic [7:0] rx_byte;
    logic [AW-1:0] addr_reg;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .mosi      (mosi_s),
        .cs_n      (cs_n_s),
        .sclk_rise (sclk_rise),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .settled   (settled)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // a frame only opens once cs_n has been seen high since reset
    always_comb begin
        state_nx = (state == IDLE) ? ((cs_fall && armed) ? ADDR : IDLE)
                 : cs_rise ? IDLE
                 : (state == ADDR && byte_done) ? DATA : state;
    end

    always_comb begin
        busy      = state != IDLE;
        shift     = busy && sclk_rise && !cs_rise;
        byte_done = shift && bit_cnt == 3'd7;
        write     = byte_done && state == DATA;
        rx_byte   = {sh, mosi_s};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            bit_cnt   <= '0;
            sh        <= '0;
            addr_reg  <= '0;
            cfg_we    <= 1'b0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            frame_err <= 1'b0;
            wr_count  <= '0;
        end else begin
            armed     <= armed || (settled && cs_n_s);
            cfg_we    <= write;
            frame_err <= busy && cs_rise && bit_cnt != 3'd0;
            if (state == IDLE && cs_fall) begin
                bit_cnt <= '0;
                sh      <= '0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + 3'd1;
                sh      <= rx_byte[6:0];
            end
            if (byte_done && state == ADDR) addr_reg <= AW'(rx_byte);
            if (write) begin
                cfg_addr  <= addr_reg;
                cfg_wdata <= rx_byte;
                addr_reg  <= addr_reg + AW'(1);
                wr_count  <= wr_count + 8'd1;
            end
        end
    end
endmodule
